// File: rtl/dmem_uart_tx.sv
// rtl/dmem_uart_tx.sv - memory-mapped 8N1 UART transmitter on the CPU data-memory bus
// TX FIFO fed by stores, STATUS/BAUDDIV registers, serialiser FSM with live baud divisor.
module dmem_uart_tx #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0001_0000,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [15:0]       DEFAULT_DIV = 16'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic [3:0]        byte_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              tx,
  output logic              irq_empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          overflow;
  logic [15:0]   baud_div, eff_div;
  logic [15:0]   clk_cnt, clk_cnt_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;
  logic          sel, full, empty, busy, bit_end;
  logic          push_req, push_ok, pop;
  logic [1:0]    offset;
  logic          unused_bits;

  assign sel      = (addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign offset   = addr[3:2];
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = sel && wen && (offset == 2'd0) && byte_en[0];
  // A full FIFO still accepts the push when the FSM frees a slot on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign eff_div  = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_end  = (clk_cnt >= eff_div - 16'd1);
  assign unused_bits = ^{addr[1:0], byte_en[3:2], wdata[DATA_W-1:16]};

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        2'd1: begin
          rdata[3:0]  = {overflow, empty, full, busy};
          rdata[15:8] = 8'(count);
        end
        2'd2:    rdata[15:0] = baud_div;
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next   = state;
    tx_next      = tx;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    clk_cnt_next = clk_cnt;
    pop          = 1'b0;
    if (state != IDLE) clk_cnt_next = bit_end ? 16'd0 : clk_cnt + 16'd1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr];
          bit_cnt_next = 3'd0;
          clk_cnt_next = 16'd0;
          state_next   = START;
          tx_next      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = shift >> 1;
            tx_next      = shift[1];
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      baud_div  <= DEFAULT_DIV;
      clk_cnt   <= 16'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
    end else begin
      state     <= state_next;
      tx        <= tx_next;
      irq_empty <= (count_next == '0) && (state_next == IDLE);
      shift     <= shift_next;
      bit_cnt   <= bit_cnt_next;
      clk_cnt   <= clk_cnt_next;
      count     <= count_next;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
      if (sel && wen && offset == 2'd1 && byte_en[0] && wdata[3]) overflow <= 1'b0;
      if (sel && wen && offset == 2'd2) begin
        if (byte_en[0]) baud_div[7:0]  <= wdata[7:0];
        if (byte_en[1]) baud_div[15:8] <= wdata[15:8];
      end
    end
  end
endmodule
